sync_fifo_2048x16: RTL and testbench
====================================

SYNC_FIFO_2048X16 -- requirements
Module: sync_fifo_2048x16

Interface
REQ-001 Parameter WR_DEPTH_WIDTH, default 11: log2 of write depth (2048 words).
REQ-002 Parameter WR_DATA_WIDTH, default 16: write word width.
REQ-003 Parameter RD_DEPTH_WIDTH, default 11 and RD_DATA_WIDTH, default 16: SHALL equal the write values (symmetric FIFO only).
REQ-004 Parameter ALMOST_FULL_NUM, default 1020: almost_full threshold in words.
REQ-005 Parameter ALMOST_EMPTY_NUM, default 4: almost_empty threshold in words.
REQ-006 Parameter OUTPUT_REG, default 0: extra output register stage; only 0 is required.
REQ-007 clk  in  1  single clock for both ports.
REQ-008 rst  in  1  reset tb_rst, asynchronous, active-high; clock clk.
REQ-009 wr_data  in  16  write word.
REQ-010 wr_en  in  1  write request.
REQ-011 wr_full  out  1  FIFO holds 2048 words.
REQ-012 almost_full  out  1  occupancy >= ALMOST_FULL_NUM.
REQ-013 rd_data  out  16  read word.
REQ-014 rd_en  in  1  read request.
REQ-015 rd_empty  out  1  FIFO holds 0 words.
REQ-016 almost_empty  out  1  occupancy <= ALMOST_EMPTY_NUM.

Function
REQ-017 Storage SHALL be 2048 x 16, first-in first-out; occupancy range is 0..2048, held in a 12-bit count.
REQ-018 A write SHALL occur on a rising clk edge when wr_en=1 and wr_full=0; wr_en while full SHALL be ignored, with no data or pointer change.
REQ-019 A read SHALL occur on a rising clk edge when rd_en=1 and rd_empty=0; rd_en while empty SHALL be ignored and rd_data SHALL hold its last value.
REQ-020 Read latency SHALL be 1 cycle: the word read at edge N is valid on rd_data after edge N and stays stable until the next accepted read.
REQ-021 Pointers SHALL be 12 bits (11 address bits plus a wrap bit) and SHALL wrap naturally from 2047 to 0.
REQ-022 A simultaneous accepted read and write SHALL leave occupancy unchanged; in that case full and empty SHALL not change.
REQ-023 When full, a simultaneous wr_en and rd_en SHALL perform only the read; when empty, they SHALL perform only the write.
REQ-024 All four flags SHALL be registered and updated on the same edge as the pointers, from the next-state occupancy, with no extra lag.
REQ-025 wr_full=1 iff occupancy=2048; rd_empty=1 iff occupancy=0.
REQ-026 almost_full=1 iff occupancy>=1020; almost_empty=1 iff occupancy<=4.
REQ-027 A write to an empty FIFO SHALL deassert rd_empty on the write edge, so the word is readable from the next cycle.

Reset
REQ-028 rst=1 SHALL asynchronously clear the pointers and occupancy.
REQ-029 During reset: rd_empty=1, almost_empty=1, wr_full=0, almost_full=0, rd_data=0.
REQ-030 Reset during operation SHALL discard all contents; RAM contents need not be cleared.
REQ-031 Reset release SHALL be usable synchronously to clk; the first write is accepted on the first edge after rst falls.
REQ-032 The module SHALL NOT depend on the global reset primitive GTP_GRS, which the bench ties inactive (GRS_N=1).

Structure
REQ-033 Depth, width and threshold constants SHALL live in a shared package, sync_fifo_pkg.
REQ-034 One sub-module, sync_fifo_sdp_ram_2048x16, SHALL be used: a simple dual-port RAM with a registered read.
REQ-035 The top level SHALL contain the pointer, occupancy and flag logic only.

Verification
REQ-036 Reset, then idle -> rd_empty=1, almost_empty=1, wr_full=0, almost_full=0.
REQ-037 Write 2049 words 0xFFFF descending on consecutive cycles -> wr_full=1 after the 2048th write; the 2049th write is dropped; almost_full rises on the write that makes occupancy 1020; almost_empty falls when occupancy reaches 5.
REQ-038 Then read 2049 times -> rd_data equals 0xFFFF, 0xFFFE, ... 0xF800 in order, each 1 cycle after its rd_en; rd_empty=1 after the 2048th read; the extra read leaves rd_data=0xF800.
REQ-039 With occupancy at 10, assert rd_en and wr_en together for 50 cycles -> occupancy stays 10, all flags stable, and order is preserved.
REQ-040 When full, assert rd_en and wr_en together -> occupancy becomes 2047 and the write is dropped; when empty, the same -> occupancy becomes 1 and rd_data is unchanged.
REQ-041 Assert rst mid-stream with occupancy 700 -> flags immediately return to the reset values, and the next write/read returns only new data.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared constants and flag helpers for the 2048x16 synchronous FIFO.
// Thresholds and geometry live here so the top and the bench agree on them.
package sync_fifo_pkg;

  localparam int unsigned FIFO_ADDR_W       = 11;
  localparam int unsigned FIFO_DATA_W       = 16;
  localparam int unsigned FIFO_ALMOST_FULL  = 1020;
  localparam int unsigned FIFO_ALMOST_EMPTY = 4;

  typedef struct packed {
    logic wr_full;
    logic almost_full;
    logic rd_empty;
    logic almost_empty;
  } fifo_flags_t;

  localparam fifo_flags_t FLAGS_RST = '{wr_full: 1'b0, almost_full: 1'b0,
                                        rd_empty: 1'b1, almost_empty: 1'b1};

  function automatic fifo_flags_t calc_flags(input int unsigned count,
                                             input int unsigned depth,
                                             input int unsigned af_num,
                                             input int unsigned ae_num);
    fifo_flags_t f;
    f.wr_full      = (count == depth);
    f.almost_full  = (count >= af_num);
    f.rd_empty     = (count == 0);
    f.almost_empty = (count <= ae_num);
    return f;
  endfunction

endpackage

// File: rtl/sync_fifo_sdp_ram_2048x16.sv
// Simple dual-port RAM: one write port, one read port with a registered,
// enable-held output that clears on reset.
module sync_fifo_sdp_ram_2048x16 #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              tb_rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // NOTE: the array has no reset so it maps onto block RAM; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sync_fifo_2048x16.sv
// Synchronous FIFO top: pointers, occupancy count and registered flags
// around a simple dual-port RAM with one-cycle read latency.
module sync_fifo_2048x16
  import sync_fifo_pkg::*;
#(
  parameter int unsigned WR_DEPTH_WIDTH   = FIFO_ADDR_W,
  parameter int unsigned WR_DATA_WIDTH    = FIFO_DATA_W,
  parameter int unsigned RD_DEPTH_WIDTH   = FIFO_ADDR_W,
  parameter int unsigned RD_DATA_WIDTH    = FIFO_DATA_W,
  parameter int unsigned ALMOST_FULL_NUM  = FIFO_ALMOST_FULL,
  parameter int unsigned ALMOST_EMPTY_NUM = FIFO_ALMOST_EMPTY,
  parameter int unsigned OUTPUT_REG       = 0
) (
  input  logic                     clk,
  input  logic                     tb_rst,
  input  logic [WR_DATA_WIDTH-1:0] wr_data,
  input  logic                     wr_en,
  output logic                     wr_full,
  output logic                     almost_full,
  output logic [RD_DATA_WIDTH-1:0] rd_data,
  input  logic                     rd_en,
  output logic                     rd_empty,
  output logic                     almost_empty
);

  localparam int unsigned DEPTH = 2**WR_DEPTH_WIDTH;

  logic [WR_DEPTH_WIDTH:0]  wr_ptr;
  logic [RD_DEPTH_WIDTH:0]  rd_ptr;
  logic [WR_DEPTH_WIDTH:0]  count;
  logic [WR_DEPTH_WIDTH:0]  count_next;
  logic                     wr_accept;
  logic                     rd_accept;
  fifo_flags_t              flags;
  fifo_flags_t              flags_next;
  logic [WR_DATA_WIDTH-1:0] ram_q;

  // Flags are exact registered copies of the occupancy, so they gate requests directly.
  assign wr_accept = wr_en & ~flags.wr_full;
  assign rd_accept = rd_en & ~flags.rd_empty;

  always_comb begin
    count_next = count;
    case ({wr_accept, rd_accept})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
    flags_next = calc_flags(32'(count_next), DEPTH, ALMOST_FULL_NUM, ALMOST_EMPTY_NUM);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      flags  <= FLAGS_RST;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
      if (rd_accept) rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      flags <= flags_next;
    end
  end

  assign wr_full      = flags.wr_full;
  assign almost_full  = flags.almost_full;
  assign rd_empty     = flags.rd_empty;
  assign almost_empty = flags.almost_empty;

  sync_fifo_sdp_ram_2048x16 #(
    .ADDR_W (WR_DEPTH_WIDTH),
    .DATA_W (WR_DATA_WIDTH)
  ) u_ram (
    .clk     (clk),
    .tb_rst  (tb_rst),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr[WR_DEPTH_WIDTH-1:0]),
    .wr_data (wr_data),
    .rd_en   (rd_accept),
    .rd_addr (rd_ptr[RD_DEPTH_WIDTH-1:0]),
    .rd_data (ram_q)
  );

  // Optional extra stage adds one cycle of read latency when enabled.
  if (OUTPUT_REG != 0) begin : g_out_reg
    always_ff @(posedge clk or posedge tb_rst) begin
      if (tb_rst) rd_data <= '0;
      else        rd_data <= ram_q;
    end
  end else begin : g_no_out_reg
    assign rd_data = ram_q;
  end

endmodule

// File: tb/tb_sync_fifo_2048x16.sv
// Self-checking bench for sync_fifo_2048x16: directed scenarios plus random
// traffic, all compared against a queue-based reference model.
module tb_sync_fifo_2048x16;

  localparam int DEPTH = 2048;
  localparam int AF    = 1020;
  localparam int AE    = 4;

  logic        clk;
  logic        tb_rst;
  logic [15:0] wr_data;
  logic        wr_en;
  logic        wr_full;
  logic        almost_full;
  logic [15:0] rd_data;
  logic        rd_en;
  logic        rd_empty;
  logic        almost_empty;

  int passed = 0;
  int checks = 0;

  logic [15:0] q[$];
  logic [15:0] exp_rd;

  sync_fifo_2048x16 dut (
    .clk          (clk),
    .tb_rst       (tb_rst),
    .wr_data      (wr_data),
    .wr_en        (wr_en),
    .wr_full      (wr_full),
    .almost_full  (almost_full),
    .rd_data      (rd_data),
    .rd_en        (rd_en),
    .rd_empty     (rd_empty),
    .almost_empty (almost_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {wr_full, almost_full, rd_empty, almost_empty} from model occupancy.
  function automatic logic [3:0] model_flags();
    int n;
    n = q.size();
    return {n == DEPTH, n >= AF, n == 0, n <= AE};
  endfunction

  function automatic logic [3:0] dut_flags();
    return {wr_full, almost_full, rd_empty, almost_empty};
  endfunction

  // One clock of stimulus; the model applies the FIFO rules to its prior occupancy.
  task automatic step(input logic w, input logic r, input logic [15:0] d);
    int  sz;
    logic wr_ok, rd_ok;
    wr_en = w; rd_en = r; wr_data = d;
    @(posedge clk); #1;
    sz    = q.size();
    wr_ok = w && (sz < DEPTH);
    rd_ok = r && (sz > 0);
    if (rd_ok) exp_rd = q.pop_front();
    if (wr_ok) q.push_back(d);
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic test_reset();
    tb_rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    #2;
    checks++;
    if (dut_flags() !== 4'b0011) $display("FAIL reset_flags: got %b expected %b", dut_flags(), 4'b0011);
    else passed++;
    checks++;
    if (rd_data !== 16'h0000) $display("FAIL reset_rd_data: got %h expected %h", rd_data, 16'h0000);
    else passed++;
    @(posedge clk); #1;
    @(posedge clk); #1;
    tb_rst = 1'b0;
    q.delete(); exp_rd = '0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, '0);
      checks++;
      if (dut_flags() !== model_flags()) $display("FAIL idle_flags[%0d]: got %b expected %b", i, dut_flags(), model_flags());
      else passed++;
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH + 1; i++) begin
      step(1'b1, 1'b0, 16'(16'hFFFF - i));
      checks++;
      if (dut_flags() !== model_flags()) $display("FAIL fill_flags[%0d]: got %b expected %b", i, dut_flags(), model_flags());
      else passed++;
    end
    checks++;
    if (wr_full !== 1'b1) $display("FAIL fill_full: got %b expected 1", wr_full);
    else passed++;
  endtask

  task automatic test_drain();
    for (int i = 0; i < DEPTH + 1; i++) begin
      step(1'b0, 1'b1, '0);
      checks++;
      if (rd_data !== exp_rd || dut_flags() !== model_flags())
        $display("FAIL drain[%0d]: got data %h flags %b expected data %h flags %b",
                 i, rd_data, dut_flags(), exp_rd, model_flags());
      else passed++;
    end
    checks++;
    if (rd_data !== 16'hF800) $display("FAIL drain_last: got %h expected %h", rd_data, 16'hF800);
    else passed++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 16'($urandom));
    for (int i = 0; i < 50; i++) begin
      step(1'b1, 1'b1, 16'($urandom));
      checks++;
      if (rd_data !== exp_rd || dut_flags() !== 4'b0000)
        $display("FAIL b2b[%0d]: got data %h flags %b expected data %h flags %b",
                 i, rd_data, dut_flags(), exp_rd, 4'b0000);
      else passed++;
    end
    while (q.size() > 0) begin
      step(1'b0, 1'b1, '0);
      checks++;
      if (rd_data !== exp_rd || dut_flags() !== model_flags())
        $display("FAIL b2b_drain: got data %h flags %b expected data %h flags %b",
                 rd_data, dut_flags(), exp_rd, model_flags());
      else passed++;
    end
  endtask

  task automatic test_boundary_simul();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 16'($urandom));
    step(1'b1, 1'b1, 16'hDEAD);
    checks++;
    if (rd_data !== exp_rd || dut_flags() !== model_flags())
      $display("FAIL full_simul: got data %h flags %b expected data %h flags %b",
               rd_data, dut_flags(), exp_rd, model_flags());
    else passed++;
    while (q.size() > 0) begin
      step(1'b0, 1'b1, '0);
      checks++;
      if (rd_data !== exp_rd) $display("FAIL full_simul_drain: got %h expected %h", rd_data, exp_rd);
      else passed++;
    end
    step(1'b1, 1'b1, 16'hABCD);
    checks++;
    if (rd_data !== exp_rd || dut_flags() !== model_flags())
      $display("FAIL empty_simul: got data %h flags %b expected data %h flags %b",
               rd_data, dut_flags(), exp_rd, model_flags());
    else passed++;
    step(1'b0, 1'b1, '0);
    checks++;
    if (rd_data !== 16'hABCD) $display("FAIL empty_simul_word: got %h expected %h", rd_data, 16'hABCD);
    else passed++;
  endtask

  task automatic test_reset_midstream();
    logic [15:0] nw [3];
    for (int i = 0; i < 700; i++) step(1'b1, 1'b0, 16'($urandom));
    step(1'b0, 1'b1, '0);
    tb_rst = 1'b1;
    #1;
    checks++;
    if (dut_flags() !== 4'b0011 || rd_data !== 16'h0000)
      $display("FAIL mid_reset: got flags %b data %h expected flags %b data %h",
               dut_flags(), rd_data, 4'b0011, 16'h0000);
    else passed++;
    q.delete(); exp_rd = '0;
    @(posedge clk); #1;
    tb_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nw[i] = 16'($urandom);
      step(1'b1, 1'b0, nw[i]);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, '0);
      checks++;
      if (rd_data !== nw[(i < 3) ? i : 2] || dut_flags() !== model_flags())
        $display("FAIL post_reset_read[%0d]: got data %h flags %b expected data %h flags %b",
                 i, rd_data, dut_flags(), nw[(i < 3) ? i : 2], model_flags());
      else passed++;
    end
  endtask

  task automatic test_random();
    int wp, rp;
    for (int blk = 0; blk < 4; blk++) begin
      wp = (blk % 2 == 0) ? 70 : 30;
      rp = 100 - wp;
      for (int i = 0; i < 500; i++) begin
        step($urandom_range(99) < wp, $urandom_range(99) < rp, 16'($urandom));
        checks++;
        if (rd_data !== exp_rd || dut_flags() !== model_flags())
          $display("FAIL random[%0d.%0d]: got data %h flags %b expected data %h flags %b",
                   blk, i, rd_data, dut_flags(), exp_rd, model_flags());
        else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_boundary_simul();
    test_reset_midstream();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
